// File: rtl/axil_cfg_sequencer.sv
// AXI4-Lite master replaying a loaded WRITE/READ_CHECK/WAIT/END list; first VALID two cycles after start.
// Waits on slave READY/VALID per handshake, bounded by TIMEOUT_CYCLES; command loads ignored while busy.
module axil_cfg_sequencer #(
  parameter int C_M_AXI_ADDR_WIDTH = 16,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int CMD_DEPTH          = 64,
  parameter int TIMEOUT_CYCLES     = 1024,
  localparam int IDXW              = $clog2(CMD_DEPTH)
) (
  input  logic                            M_AXI_ACLK,
  input  logic                            M_AXI_ARESET,
  input  logic                            cmd_wr_en,
  input  logic [IDXW-1:0]                 cmd_wr_idx,
  input  logic [1:0]                      cmd_op,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   cmd_data,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   cmd_mask,
  input  logic                            start,
  input  logic                            abort,
  output logic                            busy,
  output logic                            done,
  output logic                            timeout,
  output logic [15:0]                     err_count,
  output logic [IDXW-1:0]                 err_idx,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   rd_data_last,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  input  logic [1:0]                      M_AXI_BRESP,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic                            M_AXI_ARVALID,
  input  logic                            M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                      M_AXI_RRESP,
  input  logic                            M_AXI_RVALID,
  output logic                            M_AXI_RREADY
);
  localparam int AW = C_M_AXI_ADDR_WIDTH;
  localparam int DW = C_M_AXI_DATA_WIDTH;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0] OP_WRITE = 2'd0, OP_READ = 2'd1, OP_WAIT = 2'd2, OP_END = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WR, S_WR_RESP, S_RD, S_RD_DATA, S_WAIT, S_DONE
  } state_t;

  logic [1:0]    mem_op   [CMD_DEPTH];
  logic [AW-1:0] mem_addr [CMD_DEPTH];
  logic [DW-1:0] mem_data [CMD_DEPTH];
  logic [DW-1:0] mem_mask [CMD_DEPTH];

  state_t        state;
  logic [IDXW-1:0] idx;
  logic [AW-1:0] cur_addr;
  logic [DW-1:0] cur_data, cur_mask, wcnt;
  logic [TW-1:0] tcnt;
  logic          abort_pend;

  logic fin, err_now, to_now, err_any, wr_ok, rd_bad, last, t_exp;

  always_ff @(posedge M_AXI_ACLK) begin
    if (cmd_wr_en && !busy) begin
      mem_op[cmd_wr_idx]   <= cmd_op;
      mem_addr[cmd_wr_idx] <= cmd_addr;
      mem_data[cmd_wr_idx] <= cmd_data;
      mem_mask[cmd_wr_idx] <= cmd_mask;
    end
  end

  assign M_AXI_AWADDR = cur_addr;
  assign M_AXI_ARADDR = cur_addr;
  assign M_AXI_WDATA  = cur_data;
  assign M_AXI_WSTRB  = '1;

  // A channel counts as done once its VALID has already dropped or handshakes now.
  assign wr_ok  = (!M_AXI_AWVALID || M_AXI_AWREADY) && (!M_AXI_WVALID || M_AXI_WREADY);
  assign rd_bad = (M_AXI_RRESP != 2'b00) || ((M_AXI_RDATA & cur_mask) != (cur_data & cur_mask));
  assign last   = (idx == IDXW'(CMD_DEPTH - 1));
  assign t_exp  = (tcnt == T_LAST);
  assign err_any = err_now || to_now;

  always_comb begin
    fin     = 1'b0;
    err_now = 1'b0;
    to_now  = 1'b0;
    case (state)
      S_FETCH:   fin = !abort_pend && (mem_op[idx] == OP_WAIT) && (mem_data[idx] == '0);
      S_WR:      to_now = t_exp && !wr_ok;
      S_WR_RESP: begin
        fin     = M_AXI_BVALID;
        err_now = M_AXI_BVALID && (M_AXI_BRESP != 2'b00);
        to_now  = t_exp && !M_AXI_BVALID;
      end
      S_RD:      to_now = t_exp && !M_AXI_ARREADY;
      S_RD_DATA: begin
        fin     = M_AXI_RVALID;
        err_now = M_AXI_RVALID && rd_bad;
        to_now  = t_exp && !M_AXI_RVALID;
      end
      S_WAIT:    fin = (wcnt == DW'(1));
      default:   ;
    endcase
  end

  always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
    if (M_AXI_ARESET) begin
      state         <= S_IDLE;
      idx           <= '0;
      cur_addr      <= '0;
      cur_data      <= '0;
      cur_mask      <= '0;
      wcnt          <= '0;
      tcnt          <= '0;
      abort_pend    <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      timeout       <= 1'b0;
      err_count     <= '0;
      err_idx       <= '0;
      rd_data_last  <= '0;
      M_AXI_AWVALID <= 1'b0;
      M_AXI_WVALID  <= 1'b0;
      M_AXI_BREADY  <= 1'b0;
      M_AXI_ARVALID <= 1'b0;
      M_AXI_RREADY  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort && state != S_IDLE) abort_pend <= 1'b1;
      if (err_any) begin
        if (err_count == 16'h0000) err_idx <= idx;
        if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
      end
      if (fin) begin
        if (last || abort_pend) begin
          state <= S_DONE;
          done  <= 1'b1;
        end else begin
          idx   <= idx + IDXW'(1);
          state <= S_FETCH;
        end
      end
      case (state)
        S_IDLE: if (start) begin
          busy       <= 1'b1;
          idx        <= '0;
          timeout    <= 1'b0;
          err_count  <= '0;
          abort_pend <= 1'b0;
          state      <= S_FETCH;
        end
        S_FETCH: begin
          cur_addr <= mem_addr[idx];
          cur_data <= mem_data[idx];
          cur_mask <= mem_mask[idx];
          tcnt     <= '0;
          if (abort_pend || mem_op[idx] == OP_END) begin
            state <= S_DONE;
            done  <= 1'b1;
          end else if (mem_op[idx] == OP_WRITE) begin
            M_AXI_AWVALID <= 1'b1;
            M_AXI_WVALID  <= 1'b1;
            state         <= S_WR;
          end else if (mem_op[idx] == OP_READ) begin
            M_AXI_ARVALID <= 1'b1;
            state         <= S_RD;
          end else begin
            wcnt <= mem_data[idx];
            if (mem_data[idx] != '0) state <= S_WAIT;
          end
        end
        S_WR: begin
          if (M_AXI_AWREADY) M_AXI_AWVALID <= 1'b0;
          if (M_AXI_WREADY) M_AXI_WVALID <= 1'b0;
          if (wr_ok) begin
            M_AXI_BREADY <= 1'b1;
            tcnt         <= '0;
            state        <= S_WR_RESP;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        S_WR_RESP: begin
          if (M_AXI_BVALID) M_AXI_BREADY <= 1'b0;
          else tcnt <= tcnt + TW'(1);
        end
        S_RD: begin
          if (M_AXI_ARREADY) begin
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY  <= 1'b1;
            tcnt          <= '0;
            state         <= S_RD_DATA;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        S_RD_DATA: begin
          if (M_AXI_RVALID) begin
            M_AXI_RREADY <= 1'b0;
            rd_data_last <= M_AXI_RDATA;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        S_WAIT: wcnt <= wcnt - DW'(1);
        S_DONE: begin
          busy       <= 1'b0;
          abort_pend <= 1'b0;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
      // Hung slave: the only case where a VALID/READY is withdrawn before its handshake.
      if (to_now) begin
        timeout       <= 1'b1;
        M_AXI_AWVALID <= 1'b0;
        M_AXI_WVALID  <= 1'b0;
        M_AXI_BREADY  <= 1'b0;
        M_AXI_ARVALID <= 1'b0;
        M_AXI_RREADY  <= 1'b0;
        state         <= S_DONE;
        done          <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_axil_cfg_sequencer.sv
// Directed bench for axil_cfg_sequencer with a small negedge-driven AXI4-Lite slave.
module tb_axil_cfg_sequencer;
  localparam int AW = 16, DW = 32, DEPTH = 8, IDXW = 3, TO = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic            cmd_wr_en, start, abort;
  logic [IDXW-1:0] cmd_wr_idx;
  logic [1:0]      cmd_op;
  logic [AW-1:0]   cmd_addr;
  logic [DW-1:0]   cmd_data, cmd_mask;
  logic            busy, done, timeout;
  logic [15:0]     err_count;
  logic [IDXW-1:0] err_idx;
  logic [DW-1:0]   rd_data_last;
  logic [AW-1:0]   AWADDR, ARADDR;
  logic [DW-1:0]   WDATA, RDATA;
  logic [DW/8-1:0] WSTRB;
  logic            AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic            ARVALID, ARREADY, RVALID, RREADY;
  logic [1:0]      BRESP, RRESP;

  axil_cfg_sequencer #(
    .C_M_AXI_ADDR_WIDTH(AW), .C_M_AXI_DATA_WIDTH(DW),
    .CMD_DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)
  ) dut (
    .M_AXI_ACLK(clk), .M_AXI_ARESET(rst),
    .cmd_wr_en(cmd_wr_en), .cmd_wr_idx(cmd_wr_idx), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_mask(cmd_mask),
    .start(start), .abort(abort),
    .busy(busy), .done(done), .timeout(timeout), .err_count(err_count),
    .err_idx(err_idx), .rd_data_last(rd_data_last),
    .M_AXI_AWADDR(AWADDR), .M_AXI_AWVALID(AWVALID), .M_AXI_AWREADY(AWREADY),
    .M_AXI_WDATA(WDATA), .M_AXI_WSTRB(WSTRB), .M_AXI_WVALID(WVALID), .M_AXI_WREADY(WREADY),
    .M_AXI_BRESP(BRESP), .M_AXI_BVALID(BVALID), .M_AXI_BREADY(BREADY),
    .M_AXI_ARADDR(ARADDR), .M_AXI_ARVALID(ARVALID), .M_AXI_ARREADY(ARREADY),
    .M_AXI_RDATA(RDATA), .M_AXI_RRESP(RRESP), .M_AXI_RVALID(RVALID), .M_AXI_RREADY(RREADY)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Slave knobs and observation counters.
  int w_stall = 0;
  bit ar_hang = 1'b0;
  int aw_cnt = 0, ar_cnt = 0, b_cnt = 0, aw_hi = 0, w_hi = 0, ar_hi = 0;
  int aw_rise = 0, b_cyc_last = 0, b_cyc_prev = 0;

  logic [31:0] smem [16];
  bit aw_got, w_got, b_fire, r_fire, r_pend, aw_prev;
  logic [3:0] aw_a, r_a;
  logic [31:0] w_d;
  int w_wait;

  // Handshake decisions are made at the negedge for the following posedge.
  initial begin
    for (int i = 0; i < 16; i++) smem[i] = '0;
    AWREADY = 0; WREADY = 0; BVALID = 0; BRESP = 0;
    ARREADY = 0; RVALID = 0; RDATA = '0; RRESP = 0;
    aw_got = 0; w_got = 0; b_fire = 0; r_fire = 0; r_pend = 0; aw_prev = 0;
    aw_a = '0; r_a = '0; w_d = '0; w_wait = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        AWREADY = 0; WREADY = 0; BVALID = 0; ARREADY = 0; RVALID = 0;
        aw_got = 0; w_got = 0; b_fire = 0; r_fire = 0; r_pend = 0; aw_prev = 0; w_wait = 0;
      end else begin
        if (b_fire) begin BVALID = 0; b_fire = 0; end
        if (r_fire) begin RVALID = 0; r_fire = 0; end
        if (aw_got && w_got && !BVALID) begin
          smem[aw_a] = w_d; BVALID = 1; aw_got = 0; w_got = 0;
        end
        if (BVALID && BREADY) begin
          b_fire = 1; b_cnt++; b_cyc_prev = b_cyc_last; b_cyc_last = cyc;
        end
        AWREADY = 1;
        if (AWVALID) begin aw_hi++; if (!aw_prev) aw_rise = cyc; end
        aw_prev = AWVALID;
        if (AWVALID && AWREADY) begin aw_got = 1; aw_a = AWADDR[5:2]; aw_cnt++; end
        if (WVALID) begin
          w_hi++;
          if (w_wait >= w_stall) WREADY = 1;
          else begin WREADY = 0; w_wait++; end
        end else begin
          WREADY = 0; w_wait = 0;
        end
        if (WVALID && WREADY) begin w_got = 1; w_d = WDATA; end
        if (r_pend && !RVALID) begin RVALID = 1; RDATA = smem[r_a]; r_pend = 0; end
        if (RVALID && RREADY) r_fire = 1;
        ARREADY = !ar_hang;
        if (ARVALID) ar_hi++;
        if (ARVALID && ARREADY) begin ar_cnt++; r_pend = 1; r_a = ARADDR[5:2]; end
      end
    end
  end

  int n_cmp = 0, n_bad = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input int i, input logic [1:0] op, input logic [15:0] a,
                      input logic [31:0] d, input logic [31:0] m);
    cmd_wr_en = 1; cmd_wr_idx = IDXW'(i); cmd_op = op; cmd_addr = a; cmd_data = d; cmd_mask = m;
    @(negedge clk);
    cmd_wr_en = 0;
  endtask

  // lat = posedges from the start-sampling edge's predecessor sample to the edge raising done.
  task automatic run(input string tag, input bit abort_with_start, input int abort_at, output int lat);
    int s0;
    start = 1; abort = abort_with_start; s0 = cyc;
    @(negedge clk);
    start = 0; abort = 0;
    lat = -1;
    for (int i = 1; i < 600 && lat < 0; i++) begin
      if (done) lat = cyc - s0;
      else begin
        abort = (i == abort_at);
        @(negedge clk);
      end
    end
    abort = 0;
    check_eq({tag, "_done_seen"}, 64'(lat >= 0), 64'd1);
    if (lat >= 0) begin
      @(negedge clk);
      check_eq({tag, "_busy_done_low"}, {62'd0, busy, done}, 64'd0);
    end
  endtask

  int lat, a0, r0, b0, awh0, wh0, arh0;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    cmd_wr_en = 0; cmd_wr_idx = '0; cmd_op = 0; cmd_addr = '0; cmd_data = '0; cmd_mask = '0;
    start = 0; abort = 0;
    repeat (3) @(negedge clk);
    check_eq("rst_busy_done_to", {61'd0, busy, done, timeout}, 64'd0);
    check_eq("rst_err_count", 64'(err_count), 64'd0);
    check_eq("rst_err_idx", 64'(err_idx), 64'd0);
    check_eq("rst_rd_data_last", 64'(rd_data_last), 64'd0);
    check_eq("rst_valid_ready", {59'd0, AWVALID, WVALID, BREADY, ARVALID, RREADY}, 64'd0);
    check_eq("wstrb", 64'(WSTRB), 64'hF);
    rst = 0;
    @(negedge clk);

    // Write then matching read-back.
    load(0, 2'd0, 16'h0000, 32'hDEADBEEF, 32'h0);
    load(1, 2'd1, 16'h0000, 32'hDEADBEEF, 32'hFFFFFFFF);
    load(2, 2'd3, 16'h0000, 32'h0, 32'h0);
    a0 = aw_cnt; r0 = ar_cnt;
    run("t1", 0, 0, lat);
    check_eq("t1_aw_count", 64'(aw_cnt - a0), 64'd1);
    check_eq("t1_ar_count", 64'(ar_cnt - r0), 64'd1);
    check_eq("t1_err_count", 64'(err_count), 64'd0);
    check_eq("t1_rd_data_last", 64'(rd_data_last), 64'hDEADBEEF);

    // start and abort together: start wins, the list runs to END.
    a0 = aw_cnt;
    run("sa", 1, 0, lat);
    check_eq("sa_aw_count", 64'(aw_cnt - a0), 64'd1);
    check_eq("sa_err_count", 64'(err_count), 64'd0);

    // Read-back mismatch at entry 1, then the same with bits 0 and 3 masked.
    load(0, 2'd0, 16'h0004, 32'h7, 32'h0);
    load(1, 2'd1, 16'h0004, 32'h6, 32'hFFFFFFFF);
    run("t2a", 0, 0, lat);
    check_eq("t2a_err_count", 64'(err_count), 64'd1);
    check_eq("t2a_err_idx", 64'(err_idx), 64'd1);
    check_eq("t2a_rd_data_last", 64'(rd_data_last), 64'h7);
    load(1, 2'd1, 16'h0004, 32'h6, 32'hFFFFFFF6);
    run("t2b", 0, 0, lat);
    check_eq("t2b_err_count", 64'(err_count), 64'd0);

    // W channel stalled 5 cycles while AW is accepted immediately.
    w_stall = 5;
    load(0, 2'd0, 16'h0008, 32'h12345678, 32'h0);
    load(1, 2'd3, 16'h0000, 32'h0, 32'h0);
    awh0 = aw_hi; wh0 = w_hi; b0 = b_cnt;
    run("t3", 0, 0, lat);
    check_eq("t3_awvalid_cycles", 64'(aw_hi - awh0), 64'd1);
    check_eq("t3_wvalid_cycles", 64'(w_hi - wh0), 64'd6);
    check_eq("t3_b_count", 64'(b_cnt - b0), 64'd1);
    check_eq("t3_err_count", 64'(err_count), 64'd0);
    w_stall = 0;

    // Slave never accepts AR: 16-cycle timeout.
    ar_hang = 1;
    load(0, 2'd1, 16'h0000, 32'h0, 32'h0);
    arh0 = ar_hi;
    run("t4", 0, 0, lat);
    check_eq("t4_arvalid_cycles", 64'(ar_hi - arh0), 64'd16);
    check_eq("t4_timeout", 64'(timeout), 64'd1);
    check_eq("t4_err_count", 64'(err_count), 64'd1);
    check_eq("t4_arvalid_low", 64'(ARVALID), 64'd0);
    ar_hang = 0;

    // WAIT 20 between writes: B handshake edge is one after its sample, AW rises on its sample's edge.
    load(0, 2'd0, 16'h0010, 32'h1, 32'h0);
    load(1, 2'd2, 16'h0000, 32'd20, 32'h0);
    load(2, 2'd0, 16'h0014, 32'h2, 32'h0);
    load(3, 2'd3, 16'h0000, 32'h0, 32'h0);
    run("t5", 0, 0, lat);
    check_eq("t5_b_to_aw_edges", 64'(aw_rise - (b_cyc_prev + 1)), 64'd22);
    check_eq("t5_err_count", 64'(err_count), 64'd0);

    // No END: eight WAIT 0 entries, finishing after the last entry without wrapping.
    for (int i = 0; i < DEPTH; i++) load(i, 2'd2, 16'h0000, 32'h0, 32'h0);
    run("last", 0, 0, lat);
    check_eq("last_latency", 64'(lat), 64'd9);

    // Asynchronous reset while W is stalled, then replay of the unchanged list.
    load(0, 2'd0, 16'h0018, 32'hA5A5A5A5, 32'h0);
    load(1, 2'd1, 16'h0018, 32'hA5A5A5A5, 32'hFFFFFFFF);
    load(2, 2'd3, 16'h0000, 32'h0, 32'h0);
    w_stall = 5;
    start = 1;
    @(negedge clk);
    start = 0;
    repeat (3) @(negedge clk);
    check_eq("t6_pre_rst_wvalid", 64'(WVALID), 64'd1);
    #2 rst = 1;
    #1 check_eq("t6_async_clear", {59'd0, AWVALID, WVALID, ARVALID, BREADY, busy}, 64'd0);
    repeat (2) @(negedge clk);
    rst = 0; w_stall = 0;
    @(negedge clk);
    run("t6", 0, 0, lat);
    check_eq("t6_err_count", 64'(err_count), 64'd0);
    check_eq("t6_rd_data_last", 64'(rd_data_last), 64'hA5A5A5A5);

    // Abort during WAIT 30: done when the wait completes, following write never issued.
    load(0, 2'd2, 16'h0000, 32'd30, 32'h0);
    load(1, 2'd0, 16'h001C, 32'h5, 32'h0);
    load(2, 2'd3, 16'h0000, 32'h0, 32'h0);
    a0 = aw_cnt;
    run("abt", 0, 5, lat);
    check_eq("abt_latency", 64'(lat), 64'd32);
    check_eq("abt_aw_count", 64'(aw_cnt - a0), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
